// File: rtl/median_last_actor.sv
// median_last_actor: terminal stage of the median-filter dataflow chain.
// It pops one header token set (pivot, buff_size, median_pos and
// second_median_value), stores the residual pixels, and picks the element
// of rank K by counting. For each candidate it counts the elements that
// are smaller than it and the elements that are equal to it. The result
// goes out on a single first-word-fall-through FIFO write port.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | after reset, moves to S_HDR on the next cycle
// S_HDR    | wait until all four header FIFOs hold data, then pop them
// S_FILL   | pop N pixels and store the first BUFF_SIZE of them
// S_SELECT | one comparison per cycle: scan mem[j] against candidate mem[i]
// S_DECIDE | accept candidate i if lt <= K < lt+eq, else try the next one
// S_OUT    | hold the result and write it once the output FIFO has room

module median_last_actor #(
  parameter logic [10:0] BUFF_SIZE     = 11'd8,
  parameter int          BUFF_SIZE_BIT = $clog2(BUFF_SIZE) + 1,
  parameter logic        AVERAGE       = 1'b0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [7:0]               in_px,
  output logic                     in_px_rd,
  input  logic                     in_px_empty,
  input  logic [7:0]               in_pivot,
  output logic                     in_pivot_rd,
  input  logic                     in_pivot_empty,
  input  logic [BUFF_SIZE_BIT-1:0] in_buff_size,
  output logic                     in_buff_size_rd,
  input  logic                     in_buff_size_empty,
  input  logic [BUFF_SIZE_BIT-1:0] in_median_pos,
  output logic                     in_median_pos_rd,
  input  logic                     in_median_pos_empty,
  input  logic [7:0]               in_second_median_value,
  output logic                     in_second_median_value_rd,
  input  logic                     in_second_median_value_empty,
  output logic [7:0]               out_median,
  output logic                     out_median_wr,
  input  logic                     out_median_full
);

  localparam int ADDR_W = $clog2(BUFF_SIZE);
  localparam logic [BUFF_SIZE_BIT-1:0] DEPTH = BUFF_SIZE[BUFF_SIZE_BIT-1:0];
  localparam logic [BUFF_SIZE_BIT-1:0] ONE   = {{(BUFF_SIZE_BIT-1){1'b0}}, 1'b1};
  localparam logic [BUFF_SIZE_BIT-1:0] ZERO  = '0;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HDR    = 3'd1;
  localparam logic [2:0] S_FILL   = 3'd2;
  localparam logic [2:0] S_SELECT = 3'd3;
  localparam logic [2:0] S_DECIDE = 3'd4;
  localparam logic [2:0] S_OUT    = 3'd5;

  logic [2:0]               state_q, state_d;
  logic [BUFF_SIZE_BIT-1:0] n_q, n_d;
  logic [BUFF_SIZE_BIT-1:0] neff_q, neff_d;
  logic [BUFF_SIZE_BIT-1:0] k_q, k_d;
  logic [7:0]               s_q, s_d;
  logic [BUFF_SIZE_BIT-1:0] wcnt_q, wcnt_d;
  logic [BUFF_SIZE_BIT-1:0] i_q, i_d;
  logic [BUFF_SIZE_BIT-1:0] j_q, j_d;
  logic [BUFF_SIZE_BIT-1:0] lt_q, lt_d;
  logic [BUFF_SIZE_BIT-1:0] eq_q, eq_d;
  logic [7:0]               out_median_q, out_median_d;

  logic [7:0]               mem_q [BUFF_SIZE];
  logic                     mem_we;
  logic [ADDR_W-1:0]        mem_waddr;
  logic [7:0]               mem_wdata;

  logic                     hdr_ready;
  logic [BUFF_SIZE_BIT-1:0] neff_c;
  logic [7:0]               cand;
  logic [7:0]               scan;
  logic [BUFF_SIZE_BIT:0]   lt_eq_sum;

  // The pivot token is popped to keep the streams aligned; its value is not needed here.
  logic unused_pivot;
  assign unused_pivot = ^in_pivot;

  // Output value: either the selected element, or its rounded mean with the carried median.
  function automatic logic [7:0] result_f(input logic [7:0] sel, input logic [7:0] second);
    logic [8:0] sum;
    sum = {1'b0, sel} + {1'b0, second} + 9'd1;
    return AVERAGE ? sum[8:1] : sel;
  endfunction

  assign out_median = out_median_q;

  // Next-state, pop/write strobes and datapath updates.
  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    neff_d       = neff_q;
    k_d          = k_q;
    s_d          = s_q;
    wcnt_d       = wcnt_q;
    i_d          = i_q;
    j_d          = j_q;
    lt_d         = lt_q;
    eq_d         = eq_q;
    out_median_d = out_median_q;

    in_px_rd                  = 1'b0;
    in_pivot_rd               = 1'b0;
    in_buff_size_rd           = 1'b0;
    in_median_pos_rd          = 1'b0;
    in_second_median_value_rd = 1'b0;
    out_median_wr             = 1'b0;

    mem_we    = 1'b0;
    mem_waddr = wcnt_q[ADDR_W-1:0];
    mem_wdata = in_px;

    hdr_ready = !in_pivot_empty && !in_buff_size_empty &&
                !in_median_pos_empty && !in_second_median_value_empty;
    neff_c    = (in_buff_size > DEPTH) ? DEPTH : in_buff_size;
    cand      = mem_q[i_q[ADDR_W-1:0]];
    scan      = mem_q[j_q[ADDR_W-1:0]];
    lt_eq_sum = {1'b0, lt_q} + {1'b0, eq_q};

    case (state_q)
      S_IDLE: begin
        state_d = S_HDR;
      end

      S_HDR: begin
        if (hdr_ready) begin
          in_pivot_rd               = 1'b1;
          in_buff_size_rd           = 1'b1;
          in_median_pos_rd          = 1'b1;
          in_second_median_value_rd = 1'b1;
          n_d    = in_buff_size;
          neff_d = neff_c;
          k_d    = (neff_c != ZERO && in_median_pos >= neff_c) ? (neff_c - ONE) : in_median_pos;
          s_d    = in_second_median_value;
          wcnt_d = ZERO;
          if (in_buff_size == ZERO) begin
            // Median was already resolved upstream.
            out_median_d = result_f(in_second_median_value, in_second_median_value);
            state_d      = S_OUT;
          end else begin
            state_d = S_FILL;
          end
        end
      end

      S_FILL: begin
        if (!in_px_empty) begin
          in_px_rd = 1'b1;
          // Oversized frames are drained completely, but only the first DEPTH pixels are kept.
          if (wcnt_q < DEPTH) begin
            mem_we = 1'b1;
          end
          wcnt_d = wcnt_q + ONE;
          if (wcnt_q == n_q - ONE) begin
            state_d = S_SELECT;
            i_d     = ZERO;
            j_d     = ZERO;
            lt_d    = ZERO;
            eq_d    = ZERO;
          end
        end
      end

      S_SELECT: begin
        if (scan < cand) begin
          lt_d = lt_q + ONE;
        end
        if (scan == cand) begin
          eq_d = eq_q + ONE;
        end
        j_d = j_q + ONE;
        if (j_q == neff_q - ONE) begin
          state_d = S_DECIDE;
        end
      end

      S_DECIDE: begin
        if (lt_q <= k_q && {1'b0, k_q} < lt_eq_sum) begin
          out_median_d = result_f(cand, s_q);
          state_d      = S_OUT;
        end else begin
          i_d     = i_q + ONE;
          j_d     = ZERO;
          lt_d    = ZERO;
          eq_d    = ZERO;
          state_d = S_SELECT;
        end
      end

      S_OUT: begin
        if (!out_median_full) begin
          out_median_wr = 1'b1;
          state_d       = S_HDR;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and datapath registers; a reset abandons any frame in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      n_q          <= '0;
      neff_q       <= '0;
      k_q          <= '0;
      s_q          <= '0;
      wcnt_q       <= '0;
      i_q          <= '0;
      j_q          <= '0;
      lt_q         <= '0;
      eq_q         <= '0;
      out_median_q <= '0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      neff_q       <= neff_d;
      k_q          <= k_d;
      s_q          <= s_d;
      wcnt_q       <= wcnt_d;
      i_q          <= i_d;
      j_q          <= j_d;
      lt_q         <= lt_d;
      eq_q         <= eq_d;
      out_median_q <= out_median_d;
    end
  end

  // Pixel buffer; its contents do not matter after reset, so it has no reset.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_median_last_actor.sv
// Bench for median_last_actor. Two instances, AVERAGE=0 and AVERAGE=1, share
// one set of FIFO models. A sorting reference model predicts each frame's result.
module tb_median_last_actor;

  localparam int BSB = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [7:0]     in_px, in_pivot, in_smv;
  logic [BSB-1:0] in_bs, in_mp;
  logic           px_empty, piv_empty, bs_empty, mp_empty, smv_empty, full;

  logic           rd0_px, rd0_piv, rd0_bs, rd0_mp, rd0_smv, wr0;
  logic           rd1_px, rd1_piv, rd1_bs, rd1_mp, rd1_smv, wr1;
  logic [7:0]     out0, out1;

  median_last_actor dut0 (
    .clock(clock), .reset(reset),
    .in_px(in_px), .in_px_rd(rd0_px), .in_px_empty(px_empty),
    .in_pivot(in_pivot), .in_pivot_rd(rd0_piv), .in_pivot_empty(piv_empty),
    .in_buff_size(in_bs), .in_buff_size_rd(rd0_bs), .in_buff_size_empty(bs_empty),
    .in_median_pos(in_mp), .in_median_pos_rd(rd0_mp), .in_median_pos_empty(mp_empty),
    .in_second_median_value(in_smv), .in_second_median_value_rd(rd0_smv),
    .in_second_median_value_empty(smv_empty),
    .out_median(out0), .out_median_wr(wr0), .out_median_full(full)
  );

  median_last_actor #(.AVERAGE(1'b1)) dut1 (
    .clock(clock), .reset(reset),
    .in_px(in_px), .in_px_rd(rd1_px), .in_px_empty(px_empty),
    .in_pivot(in_pivot), .in_pivot_rd(rd1_piv), .in_pivot_empty(piv_empty),
    .in_buff_size(in_bs), .in_buff_size_rd(rd1_bs), .in_buff_size_empty(bs_empty),
    .in_median_pos(in_mp), .in_median_pos_rd(rd1_mp), .in_median_pos_empty(mp_empty),
    .in_second_median_value(in_smv), .in_second_median_value_rd(rd1_smv),
    .in_second_median_value_empty(smv_empty),
    .out_median(out1), .out_median_wr(wr1), .out_median_full(full)
  );

  logic [7:0]     q_px[$], q_piv[$], q_smv[$];
  logic [BSB-1:0] q_bs[$], q_mp[$];
  int             exp0_q[$], exp1_q[$];
  int             pxbuf[$];

  bit   px_stall = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   wr_count = 0;
  int   px_pops = 0;
  logic s_px, s_piv, s_bs, s_mp, s_smv;

  task automatic chk(input string name, input bit ok, input int act, input int expv);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // FIFO models plus the per-cycle compare process.
  initial begin
    s_px = 0; s_piv = 0; s_bs = 0; s_mp = 0; s_smv = 0;
    px_empty = 1; piv_empty = 1; bs_empty = 1; mp_empty = 1; smv_empty = 1;
    in_px = 0; in_pivot = 0; in_bs = 0; in_mp = 0; in_smv = 0;
    forever begin
      @(negedge clock);
      if (s_px  && q_px.size()  > 0) void'(q_px.pop_front());
      if (s_piv && q_piv.size() > 0) void'(q_piv.pop_front());
      if (s_bs  && q_bs.size()  > 0) void'(q_bs.pop_front());
      if (s_mp  && q_mp.size()  > 0) void'(q_mp.pop_front());
      if (s_smv && q_smv.size() > 0) void'(q_smv.pop_front());
      #1;
      px_empty  = (q_px.size() == 0) || px_stall;
      piv_empty = (q_piv.size() == 0);
      bs_empty  = (q_bs.size() == 0);
      mp_empty  = (q_mp.size() == 0);
      smv_empty = (q_smv.size() == 0);
      in_px     = (q_px.size()  > 0) ? q_px[0]  : 8'd0;
      in_pivot  = (q_piv.size() > 0) ? q_piv[0] : 8'd0;
      in_bs     = (q_bs.size()  > 0) ? q_bs[0]  : '0;
      in_mp     = (q_mp.size()  > 0) ? q_mp[0]  : '0;
      in_smv    = (q_smv.size() > 0) ? q_smv[0] : 8'd0;
      #1;
      s_px = rd0_px; s_piv = rd0_piv; s_bs = rd0_bs; s_mp = rd0_mp; s_smv = rd0_smv;
      if (!reset) begin
        chk("dut_agree", {rd1_px, rd1_piv, rd1_bs, rd1_mp, rd1_smv, wr1} ==
                         {rd0_px, rd0_piv, rd0_bs, rd0_mp, rd0_smv, wr0},
            int'({rd1_px, rd1_piv, rd1_bs, rd1_mp, rd1_smv, wr1}),
            int'({rd0_px, rd0_piv, rd0_bs, rd0_mp, rd0_smv, wr0}));
        if (rd0_px) begin
          px_pops++;
          chk("px_rd_on_empty", !px_empty, int'(px_empty), 0);
        end
        if (rd0_piv || rd0_bs || rd0_mp || rd0_smv) begin
          chk("hdr_pop_together", rd0_piv && rd0_bs && rd0_mp && rd0_smv,
              int'({rd0_piv, rd0_bs, rd0_mp, rd0_smv}), 15);
          chk("hdr_rd_on_empty", !(piv_empty || bs_empty || mp_empty || smv_empty),
              int'({piv_empty, bs_empty, mp_empty, smv_empty}), 0);
        end
        if (wr0) begin
          wr_count++;
          chk("wr_while_full", !full, int'(full), 0);
          if (exp0_q.size() == 0) begin
            chk("unexpected_wr", 1'b0, 1, 0);
          end else begin
            int e0, e1;
            e0 = exp0_q.pop_front();
            e1 = exp1_q.pop_front();
            chk("out_median", out0 == e0[7:0], int'(out0), e0);
            chk("out_median_avg", out1 == e1[7:0], int'(out1), e1);
          end
        end
      end
    end
  end

  // Reference: sort the stored pixels, clamp K, pick by rank.
  task automatic push_frame(input int n, input int k, input int s, input bit score,
                            input int lit0, input int lit1);
    int st[$];
    int m0, m1, kk;
    for (int i = 0; i < n; i++) begin
      q_px.push_back(pxbuf[i][7:0]);
      if (i < 8) st.push_back(pxbuf[i]);
    end
    st.sort();
    if (n == 0) begin
      m0 = s;
    end else begin
      kk = (k >= st.size()) ? st.size() - 1 : k;
      m0 = st[kk];
    end
    m1 = (m0 + s + 1) >> 1;
    if (score) begin
      chk("model_pin", m0 == lit0, m0, lit0);
      chk("model_pin_avg", m1 == lit1, m1, lit1);
      exp0_q.push_back(m0);
      exp1_q.push_back(m1);
    end
    q_piv.push_back(8'(n + 8'h5A));
    q_bs.push_back(n[BSB-1:0]);
    q_mp.push_back(k[BSB-1:0]);
    q_smv.push_back(s[7:0]);
  endtask

  task automatic wait_wr(input int maxc, input string name, output int lat);
    int start;
    start = wr_count;
    lat = -1;
    for (int c = 1; c <= maxc; c++) begin
      @(negedge clock);
      #3;
      if (wr_count != start) begin
        lat = c;
        break;
      end
    end
    if (lat < 0) chk({name, "_timeout"}, 1'b0, maxc, 0);
  endtask

  task automatic chk_drained(input string name);
    int left;
    left = q_px.size() + q_piv.size() + q_bs.size() + q_mp.size() + q_smv.size();
    chk(name, left == 0, left, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, pops0, wc0;
    full = 1'b0;
    repeat (3) @(negedge clock);
    #3;
    chk("reset_out", out0 == 8'd0 && out1 == 8'd0, int'(out0), 0);
    chk("reset_strobes", {rd0_px, rd0_piv, rd0_bs, rd0_mp, rd0_smv, wr0} == 6'd0,
        int'({rd0_px, rd0_piv, rd0_bs, rd0_mp, rd0_smv, wr0}), 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Plain frame: sorted {1,2,3,4,5,7,8,9}, rank 4 -> 5.
    pxbuf = '{5, 3, 9, 1, 7, 2, 8, 4};
    push_frame(8, 4, 0, 1'b1, 5, 3);
    wait_wr(200, "t1", lat);
    chk_drained("t1_drained");
    @(negedge clock);

    // Duplicates: candidate 0 (value 6) has lt=1, eq=3 and must win on the first scan.
    pxbuf = '{6, 6, 1, 6, 9};
    push_frame(5, 2, 0, 1'b1, 6, 3);
    wait_wr(100, "t2", lat);
    chk("t2_first_scan_latency", lat == 12, lat, 12);
    chk_drained("t2_drained");
    @(negedge clock);

    // Empty buffer: the carried value passes straight through, no pixel pops.
    pxbuf = {};
    pops0 = px_pops;
    push_frame(0, 0, 42, 1'b1, 42, 42);
    wait_wr(20, "t3", lat);
    chk("t3_latency", lat == 1, lat, 1);
    chk("t3_no_px_rd", px_pops == pops0, px_pops - pops0, 0);
    @(negedge clock);

    // Starvation mid-fill and output backpressure.
    full = 1'b1;
    pxbuf = '{5, 3, 9, 1, 7, 2, 8, 4};
    push_frame(8, 4, 0, 1'b1, 5, 3);
    wc0 = wr_count;
    repeat (3) @(negedge clock);
    px_stall = 1'b1;
    repeat (10) @(negedge clock);
    px_stall = 1'b0;
    repeat (47) @(negedge clock);
    chk("t4_no_wr_while_full", wr_count == wc0, wr_count - wc0, 0);
    full = 1'b0;
    wait_wr(20, "t4", lat);
    chk_drained("t4_drained");
    repeat (5) @(negedge clock);
    chk("t4_single_pulse", wr_count == wc0 + 1, wr_count - wc0, 1);

    // Averaging: sel=20, (20+31+1)>>1 = 26.
    pxbuf = '{10, 20, 30, 40};
    push_frame(4, 1, 31, 1'b1, 20, 26);
    wait_wr(100, "t5", lat);
    @(negedge clock);

    // Oversized frame: 10 pixels, only 8 stored, K=9 clamps to 7 -> max of first 8 = 9.
    pxbuf = '{3, 1, 4, 1, 5, 9, 2, 6, 50, 60};
    push_frame(10, 9, 7, 1'b1, 9, 8);
    wait_wr(200, "t_oversize", lat);
    chk_drained("t_oversize_drained");
    @(negedge clock);

    // Reset during the selection of frame A, then frame B.
    pxbuf = '{8, 7, 6, 5, 4, 3, 2, 1};
    push_frame(8, 0, 0, 1'b0, 0, 0);
    for (int c = 0; c < 50 && q_px.size() > 0; c++) @(negedge clock);
    chk("t6_a_filled", q_px.size() == 0, q_px.size(), 0);
    repeat (4) @(negedge clock);
    wc0 = wr_count;
    reset = 1'b1;
    #3;
    chk("t6_reset_out", out0 == 8'd0, int'(out0), 0);
    chk("t6_reset_out_avg", out1 == 8'd0, int'(out1), 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    chk("t6_no_wr_for_a", wr_count == wc0, wr_count - wc0, 0);
    @(negedge clock);
    pxbuf = '{200, 100, 150};
    push_frame(3, 0, 0, 1'b1, 100, 50);
    wait_wr(100, "t6", lat);
    repeat (100) @(negedge clock);
    chk("t6_single_wr", wr_count == wc0 + 1, wr_count - wc0, 1);
    chk("scoreboard_empty", exp0_q.size() == 0, exp0_q.size(), 0);
    chk_drained("t6_drained");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
